// File: rtl/gpr_sb.sv
// Register file with two write ports, two bypassed read ports and a
// per-register pending scoreboard used to track in-flight producers.
module gpr_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic          issue,
    input  logic [AW-1:0] issue_a,
    input  logic          flush,
    output logic          pend1,
    output logic          pend2,
    output logic [AW:0]   pend_cnt
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [AW:0]     pend_cnt_q;
    logic [AW:0]     pend_cnt_d;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;

    logic zero1;
    logic zero2;
    logic hit0_1;
    logic hit1_1;
    logic hit0_2;
    logic hit1_2;

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (we0) begin
            regs_d[wa0] = wd0;
        end
        if (we1) begin
            regs_d[wa1] = wd1;
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
    end

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (we0) begin
            clr_vec[wa0] = 1'b1;
        end
        if (we1) begin
            clr_vec[wa1] = 1'b1;
        end
        if (issue) begin
            set_vec[issue_a] = 1'b1;
        end
        // Set is OR-ed after the clear so issue beats a same-cycle writeback.
        pend_d = flush ? '0 : ((pend_q & ~clr_vec) | set_vec);
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
        pend_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_comb begin
        zero1  = (ZERO_REG != 0) && (ra1 == '0);
        zero2  = (ZERO_REG != 0) && (ra2 == '0);
        hit0_1 = we0 && (wa0 == ra1);
        hit1_1 = we1 && (wa1 == ra1);
        hit0_2 = we0 && (wa0 == ra2);
        hit1_2 = we1 && (wa1 == ra2);

        rd1 = regs_q[ra1];
        if (zero1) begin
            rd1 = '0;
        end else if (hit1_1) begin
            rd1 = wd1;
        end else if (hit0_1) begin
            rd1 = wd0;
        end

        rd2 = regs_q[ra2];
        if (zero2) begin
            rd2 = '0;
        end else if (hit1_2) begin
            rd2 = wd1;
        end else if (hit0_2) begin
            rd2 = wd0;
        end

        pend1 = pend_q[ra1] && !hit0_1 && !hit1_1 && !zero1;
        pend2 = pend_q[ra2] && !hit0_2 && !hit1_2 && !zero2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: doc/gpr_sb.md
GPR_SB -- requirements
Module: gpr_sb

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter AW, default 5, register address width; register count NREG = 2**AW.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 reads 0, ignores writes, never becomes pending.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ra1, ra2  input  AW  read addresses.
REQ-007 rd1, rd2  output  DW  read data, combinational.
REQ-008 we0, wa0, wd0  input  1/AW/DW  write port 0 enable, address, data.
REQ-009 we1, wa1, wd1  input  1/AW/DW  write port 1 enable, address, data.
REQ-010 issue, issue_a  input  1/AW  mark register issue_a pending, i.e. it has an in-flight producer.
REQ-011 flush  input  1  clear all pending bits.
REQ-012 pend1, pend2  output  1  pending status of ra1, ra2, combinational.
REQ-013 pend_cnt  output  AW+1  number of registers currently pending, registered.

Function
REQ-014 Write: a register is loaded with the write data at the clock edge when its port enable is set.
- Both ports enabled with the same address: port 1 wins.
REQ-015 Read bypass: rdN returns write data in the same cycle when a write to raN is enabled. Priority: port 1 data, then port 0 data, then stored value.
REQ-016 With ZERO_REG=1, rdN = 0 whenever raN = 0, regardless of writes or bypass.
REQ-017 Pending clear: a write on either port to address a clears pending[a] at the edge.
REQ-018 Pending set: issue sets pending[issue_a] at the edge.
- Set and clear of the same address in one cycle: set wins.
- Issue to address 0 with ZERO_REG=1 is ignored.
REQ-019 pendN = pending[raN] AND NOT (a write to raN is enabled this cycle). pendN is 0 for address 0 when ZERO_REG=1.
REQ-020 flush clears every pending bit and resets pend_cnt to 0 at the edge.
- flush has priority over issue and over write clears in the same cycle.
- flush does not affect register contents; enabled writes still complete.
REQ-021 pend_cnt next value equals the population count of the next pending vector.
- Both write ports clearing the same pending address decrements the count by exactly 1.
- Set of an already-pending register leaves the count unchanged.
- The count never wraps; its maximum is NREG, or NREG-1 with ZERO_REG=1.
REQ-022 No read or issue stall logic is internal to the block; consumers combine pendN with their own issue logic.

Reset
REQ-023 While reset_n = 0, asynchronously and independent of clk: all registers = 0, all pending bits = 0, pend_cnt = 0.
REQ-024 Writes, issue and flush are ignored while reset_n = 0.
REQ-025 Normal operation resumes at the first rising clk edge after reset_n deasserts.
REQ-026 An assertion of reset_n mid-operation discards in-flight pending state without completing writes.

Verification
REQ-027 Reset, then we0=1, wa0=3, wd0=0xDEADBEEF with ra1=3 in the same cycle -> rd1=0xDEADBEEF combinationally; rd1 still 0xDEADBEEF next cycle with we0=0.
REQ-028 we0=1, wa0=7, wd0=0x11 and we1=1, wa1=7, wd1=0x22 in one cycle -> rd1 (ra1=7) = 0x22 that cycle, and register 7 holds 0x22 afterwards.
REQ-029 we1=1, wa1=0, wd1=0xFFFFFFFF; issue=1, issue_a=0 -> rd1 (ra1=0) = 0, pend1=0, pend_cnt stays 0.
REQ-030 Pending sequence:
- issue to 5, then issue to 9 -> pend_cnt = 2.
- Next cycle: write 5 while ra1=5 -> pend1=0 that cycle; pend_cnt = 1 after the edge.
- Next cycle: issue to 9 together with write 9 -> pend_cnt stays 1 and pending[9] stays set.
REQ-031 Set 4 pending registers, then assert flush together with issue to 12 -> pend_cnt = 0 and pend2 (ra2=12) = 0 next cycle.
REQ-032 Assert reset_n = 0 between clock edges with pend_cnt = 3 and register 5 = 0x55 -> pend_cnt = 0 and rd1 (ra1=5) = 0 immediately, without a clock edge.
